// File: rtl/gate_input_debounce.sv
`default_nettype none
// ============================================================================
// Module   : gate_input_debounce
// Brief    : Synchronizes and debounces raw switch levels feeding m/n/u/v,
//            with one-cycle rise/fall pulses and an all-settled flag.
// Revision : 1.0 - initial release
// ============================================================================
module gate_input_debounce #(
    parameter int WIDTH   = 4,
    parameter int CNT_MAX = 50000,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw_in,
    output logic [WIDTH-1:0] sw_out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             stable
);

    // Terminal count: a mismatch seen on this count is accepted on the same edge.
    localparam logic [CNT_W-1:0] c_last = CNT_W'(CNT_MAX - 1);

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= sw_in;
            r_sync2 <= r_sync1;
        end
    end

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_chan
            logic [CNT_W-1:0] r_cnt;
            logic             r_out;
            logic             r_rise;
            logic             r_fall;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_cnt  <= '0;
                    r_out  <= 1'b0;
                    r_rise <= 1'b0;
                    r_fall <= 1'b0;
                end else begin
                    r_rise <= 1'b0;
                    r_fall <= 1'b0;
                    // Any return to the accepted level discards the partial count.
                    if (r_sync2[i] == r_out) begin
                        r_cnt <= '0;
                    end else if (r_cnt == c_last) begin
                        r_cnt  <= '0;
                        r_out  <= r_sync2[i];
                        r_rise <= r_sync2[i];
                        r_fall <= ~r_sync2[i];
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
            end

            assign sw_out[i] = r_out;
            assign rise[i]   = r_rise;
            assign fall[i]   = r_fall;
        end
    endgenerate

    assign stable = (r_sync2 == sw_out);

endmodule
`default_nettype wire
